// File: rtl/seq_slice_adder_pkg.sv
// Shared definitions for the sequential slice adder:
// FSM state encoding and a counter-width helper.
package adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_slice_adder_slice.sv
// Combinational SLICE-bit ripple of full-adder cells.
// Also exports the carry into the slice MSB for overflow.
module slice_ripple_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_s,
  output logic             o_c_out,
  output logic             o_c_msb_in
);

  logic [SLICE:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_c;
    for (int i = 0; i < SLICE; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) |
                 (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_c_out    = w_c[SLICE];
  assign o_c_msb_in = w_c[SLICE-1];

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle add/sub: one SLICE-bit ripple reused NSLICE
// times, LSB first, with valid/ready on both sides.
module seq_slice_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_w(NSLICE);
  localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("WIDTH must be a multiple of SLICE");
  end

  state_t           r_state;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [SLICE-1:0] w_s;
  logic             w_co;
  logic             w_cm;
  logic [WIDTH-1:0] w_sum_next;

  slice_ripple_adder #(.SLICE(SLICE)) u_slice (
    .i_a        (r_a[SLICE-1:0]),
    .i_b        (r_b[SLICE-1:0]),
    .i_c        (r_c),
    .o_s        (w_s),
    .o_c_out    (w_co),
    .o_c_msb_in (w_cm)
  );

  // Operands shift down, result fills in from the top.
  assign w_sum_next = (r_sum >> SLICE) |
                      (WIDTH'(w_s) << (WIDTH - SLICE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_c        <= sub ? ~cin : cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> SLICE;
          r_b   <= r_b >> SLICE;
          r_c   <= w_co;
          r_sum <= w_sum_next;
          if (r_k == K_LAST) begin
            r_cout      <= w_co;
            r_ovf       <= w_cm ^ w_co;
            r_zero      <= (w_sum_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
